// File: rtl/irig_sync_ctrl.sv
// irig_sync_ctrl: disciplines a local seconds/sub-seconds time base to an
// IRIG decoder's second pulse, free-runs through short pps outages
// (holdover), regenerates a second pulse, and offers a one-deep event
// capture register with overrun flag.
//
// Ports:
//   clk, rst (async, active-low)
//   pps, ts_sec_day[16:0]     decoder second boundary + seconds-of-day
//   cap_strobe, cap_ack       capture request / consumer read acknowledge
//   state[1:0], locked        sync FSM state (0 UNLOCKED,1 ACQUIRE,2 LOCKED,3 HOLDOVER)
//   pps_out                   regenerated 1-cycle second pulse (registered)
//   sec_out[16:0], subsec_out[23:0]   local time base
//   cap_valid, cap_sec, cap_subsec, cap_locked, cap_overrun   capture registers
//
// Capture handshake: cap_strobe is a request pulse; the snapshot is taken
// when cap_valid is low, or when cap_ack arrives in the same cycle (the ack
// frees the register that very cycle). A strobe that finds cap_valid high
// without an ack is dropped and recorded in sticky cap_overrun until ack.
module irig_sync_ctrl #(
  parameter int CLK_HZ     = 10000000,
  parameter int TOL        = 100,
  parameter int HOLDOVER_S = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pps,
  input  logic [16:0] ts_sec_day,
  input  logic        cap_strobe,
  input  logic        cap_ack,
  output logic [1:0]  state,
  output logic        locked,
  output logic        pps_out,
  output logic [16:0] sec_out,
  output logic [23:0] subsec_out,
  output logic        cap_valid,
  output logic [16:0] cap_sec,
  output logic [23:0] cap_subsec,
  output logic        cap_locked,
  output logic        cap_overrun
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_e;

  localparam logic [31:0] GOOD_LO = 32'(CLK_HZ - 1 - TOL);
  localparam logic [31:0] GOOD_HI = 32'(CLK_HZ - 1 + TOL);
  localparam logic [31:0] HOLD_AT = 32'(CLK_HZ + TOL - 1);
  localparam logic [31:0] ACQ_TO  = 32'(CLK_HZ + TOL);
  localparam logic [31:0] WRAP_AT = 32'(CLK_HZ - 1);
  localparam logic [23:0] TOL_SS  = 24'(TOL);
  localparam logic [15:0] HO_LIM  = 16'(HOLDOVER_S);
  localparam logic [16:0] SEC_MAX = 17'd86399;

  state_e      state_q, state_d;
  logic [23:0] subsec_q, subsec_d;
  logic [16:0] sec_q, sec_d;
  logic        good_q, good_d;       // one good pps already seen in ACQUIRE
  logic [15:0] ho_q, ho_d;           // seconds spent in holdover
  logic        pps_out_q, pps_out_d;

  logic        cap_valid_q, cap_valid_d;
  logic [16:0] cap_sec_q, cap_sec_d;
  logic [23:0] cap_subsec_q, cap_subsec_d;
  logic        cap_locked_q, cap_locked_d;
  logic        cap_ovr_q, cap_ovr_d;

  logic [31:0] sub32;
  logic        ts_ok, pps_good, locked_w;
  logic [16:0] sec_inc;
  logic [23:0] subsec_inc;

  assign sub32      = {8'd0, subsec_q};
  assign ts_ok      = (ts_sec_day <= SEC_MAX);
  assign pps_good   = pps && ts_ok && (sub32 >= GOOD_LO) && (sub32 <= GOOD_HI);
  assign sec_inc    = (sec_q == SEC_MAX) ? 17'd0 : sec_q + 17'd1;
  assign subsec_inc = (subsec_q == 24'hFFFFFF) ? subsec_q : subsec_q + 24'd1;
  assign locked_w   = (state_q == LOCKED) || (state_q == HOLDOVER);

  // Sync FSM and time base.
  always_comb begin
    state_d   = state_q;
    subsec_d  = subsec_inc;
    sec_d     = sec_q;
    good_d    = good_q;
    ho_d      = ho_q;
    pps_out_d = 1'b0;

    // A pps always realigns the time base, whatever the state.
    if (pps) begin
      subsec_d = 24'd0;
      if (ts_ok) sec_d = ts_sec_day;
    end

    case (state_q)
      UNLOCKED: begin
        if (pps) begin
          state_d = ACQUIRE;
          good_d  = 1'b0;
        end
      end
      ACQUIRE: begin
        if (pps) begin
          if (pps_good) begin
            if (good_q) begin
              state_d   = LOCKED;
              good_d    = 1'b0;
              pps_out_d = 1'b1;
            end else begin
              good_d = 1'b1;
            end
          end else begin
            good_d = 1'b0;
          end
        end else if (sub32 >= ACQ_TO) begin
          state_d = UNLOCKED;
          good_d  = 1'b0;
        end
      end
      LOCKED: begin
        if (pps) begin
          if (pps_good) begin
            pps_out_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
            good_d  = 1'b0;
          end
        end else if (sub32 == HOLD_AT) begin
          // Pulse is TOL cycles late, so the local second is TOL cycles old.
          state_d   = HOLDOVER;
          subsec_d  = TOL_SS;
          sec_d     = sec_inc;
          ho_d      = 16'd1;
          pps_out_d = 1'b1;
        end
      end
      HOLDOVER: begin
        if (pps) begin
          state_d = ACQUIRE;
          good_d  = 1'b0;
          ho_d    = 16'd0;
        end else if (sub32 == WRAP_AT) begin
          subsec_d  = 24'd0;
          sec_d     = sec_inc;
          pps_out_d = 1'b1;
          ho_d      = ho_q + 16'd1;
          if (ho_q + 16'd1 >= HO_LIM) begin
            state_d = UNLOCKED;
            ho_d    = 16'd0;
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Capture registers; snapshot uses current-cycle (pre-pps) values.
  always_comb begin
    cap_valid_d  = cap_valid_q;
    cap_sec_d    = cap_sec_q;
    cap_subsec_d = cap_subsec_q;
    cap_locked_d = cap_locked_q;
    cap_ovr_d    = cap_ovr_q;
    if (cap_ack) begin
      cap_valid_d = 1'b0;
      cap_ovr_d   = 1'b0;
    end
    if (cap_strobe) begin
      if (!cap_valid_q || cap_ack) begin
        cap_valid_d  = 1'b1;
        cap_sec_d    = sec_q;
        cap_subsec_d = subsec_q;
        cap_locked_d = locked_w;
      end else begin
        cap_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= UNLOCKED;
      subsec_q     <= 24'd0;
      sec_q        <= 17'd0;
      good_q       <= 1'b0;
      ho_q         <= 16'd0;
      pps_out_q    <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_sec_q    <= 17'd0;
      cap_subsec_q <= 24'd0;
      cap_locked_q <= 1'b0;
      cap_ovr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      subsec_q     <= subsec_d;
      sec_q        <= sec_d;
      good_q       <= good_d;
      ho_q         <= ho_d;
      pps_out_q    <= pps_out_d;
      cap_valid_q  <= cap_valid_d;
      cap_sec_q    <= cap_sec_d;
      cap_subsec_q <= cap_subsec_d;
      cap_locked_q <= cap_locked_d;
      cap_ovr_q    <= cap_ovr_d;
    end
  end

  assign state       = state_q;
  assign locked      = locked_w;
  assign pps_out     = pps_out_q;
  assign sec_out     = sec_q;
  assign subsec_out  = subsec_q;
  assign cap_valid   = cap_valid_q;
  assign cap_sec     = cap_sec_q;
  assign cap_subsec  = cap_subsec_q;
  assign cap_locked  = cap_locked_q;
  assign cap_overrun = cap_ovr_q;

endmodule

// File: tb/tb_irig_sync_ctrl.sv
// Directed bench for irig_sync_ctrl with CLK_HZ=1000, TOL=10, HOLDOVER_S=3.
// Inputs change and outputs are sampled on the falling edge; ss tracks the
// expected subsec_out visible at the current falling edge.
module tb_irig_sync_ctrl;
  localparam int CLK_HZ     = 1000;
  localparam int TOL        = 10;
  localparam int HOLDOVER_S = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pps;
  logic [16:0] ts_sec_day;
  logic        cap_strobe;
  logic        cap_ack;
  logic [1:0]  state;
  logic        locked;
  logic        pps_out;
  logic [16:0] sec_out;
  logic [23:0] subsec_out;
  logic        cap_valid;
  logic [16:0] cap_sec;
  logic [23:0] cap_subsec;
  logic        cap_locked;
  logic        cap_overrun;

  irig_sync_ctrl #(.CLK_HZ(CLK_HZ), .TOL(TOL), .HOLDOVER_S(HOLDOVER_S)) dut (
    .clk(clk), .rst(rst), .pps(pps), .ts_sec_day(ts_sec_day),
    .cap_strobe(cap_strobe), .cap_ack(cap_ack),
    .state(state), .locked(locked), .pps_out(pps_out),
    .sec_out(sec_out), .subsec_out(subsec_out),
    .cap_valid(cap_valid), .cap_sec(cap_sec), .cap_subsec(cap_subsec),
    .cap_locked(cap_locked), .cap_overrun(cap_overrun)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors    = 0;
  int checks    = 0;
  int ss        = 0;
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(negedge clk);
    ss++;
    if (pps_out === 1'b1) pulse_cnt++;
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  task automatic go_to(input int t);
    adv(t - ss);
  endtask

  task automatic pulse_pps(input logic [16:0] ts);
    pps        = 1'b1;
    ts_sec_day = ts;
    step();
    pps        = 1'b0;
    ts_sec_day = 17'd0;
    ss         = 0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_state"},   32'(state), 0);
    chk({p, "_locked"},  32'(locked), 0);
    chk({p, "_pps_out"}, 32'(pps_out), 0);
    chk({p, "_sec"},     32'(sec_out), 0);
    chk({p, "_subsec"},  32'(subsec_out), 0);
    chk({p, "_cvalid"},  32'(cap_valid), 0);
    chk({p, "_csec"},    32'(cap_sec), 0);
    chk({p, "_csub"},    32'(cap_subsec), 0);
    chk({p, "_clock"},   32'(cap_locked), 0);
    chk({p, "_covr"},    32'(cap_overrun), 0);
  endtask

  initial begin
    rst = 1'b0; pps = 1'b0; ts_sec_day = 17'd0; cap_strobe = 1'b0; cap_ack = 1'b0;
    #7;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    ss  = 0;
    adv(5);
    chk("free_subsec", 32'(subsec_out), 5);
    chk("free_state", 32'(state), 0);

    // Acquisition: three pps 1000 cycles apart.
    pulse_pps(17'd100);
    chk("p1_state", 32'(state), 1);
    chk("p1_sec", 32'(sec_out), 100);
    chk("p1_subsec", 32'(subsec_out), 0);
    chk("p1_ppsout", 32'(pps_out), 0);
    go_to(999); pulse_pps(17'd101);
    chk("p2_state", 32'(state), 1);
    chk("p2_sec", 32'(sec_out), 101);
    go_to(999); pulse_pps(17'd102);
    chk("p3_state", 32'(state), 2);
    chk("p3_locked", 32'(locked), 1);
    chk("p3_sec", 32'(sec_out), 102);
    chk("p3_ppsout", 32'(pps_out), 1);
    step();
    chk("p3_ppsout_1cyc", 32'(pps_out), 0);

    // Early-but-good pps, then a late one.
    go_to(994); pulse_pps(17'd103);
    chk("early_state", 32'(state), 2);
    chk("early_ppsout", 32'(pps_out), 1);
    chk("early_sec", 32'(sec_out), 103);
    go_to(1009);
    chk("late_pre_state", 32'(state), 2);
    step();
    chk("late_ho_state", 32'(state), 3);
    chk("late_ho_subsec", 32'(subsec_out), 10);
    chk("late_ho_sec", 32'(sec_out), 104);
    chk("late_ho_ppsout", 32'(pps_out), 1);
    pulse_pps(17'd104);
    chk("late_state", 32'(state), 1);
    chk("late_ppsout", 32'(pps_out), 0);
    chk("late_locked", 32'(locked), 0);

    // Re-lock at end of day, then lose pps: holdover across midnight.
    go_to(999); pulse_pps(17'd86396);
    chk("eod1_state", 32'(state), 1);
    chk("eod1_ppsout", 32'(pps_out), 0);
    go_to(999); pulse_pps(17'd86397);
    chk("eod2_state", 32'(state), 2);
    go_to(999); pulse_pps(17'd86398);
    chk("eod3_sec", 32'(sec_out), 86398);
    pulse_cnt = 0;
    adv(1009);
    step();
    chk("ho_state", 32'(state), 3);
    chk("ho_sec", 32'(sec_out), 86399);
    chk("ho_subsec", 32'(subsec_out), 10);
    ss = 10;
    go_to(999);
    chk("ho_prewrap_ppsout", 32'(pps_out), 0);
    step();
    chk("wrap1_sec", 32'(sec_out), 0);
    chk("wrap1_subsec", 32'(subsec_out), 0);
    chk("wrap1_state", 32'(state), 3);
    ss = 0;
    go_to(999);
    step();
    chk("wrap2_sec", 32'(sec_out), 1);
    chk("wrap2_state", 32'(state), 0);
    chk("wrap2_locked", 32'(locked), 0);
    ss = 0;
    adv(100);
    chk("unl_sec_hold", 32'(sec_out), 1);
    chk("ho_pulses", 32'(pulse_cnt), 3);

    // ACQUIRE timeout boundary.
    pulse_pps(17'd5);
    chk("to_state0", 32'(state), 1);
    go_to(1010);
    chk("to_at1010_state", 32'(state), 1);
    chk("to_at1010_subsec", 32'(subsec_out), 1010);
    step();
    chk("to_state", 32'(state), 0);

    // Out-of-range seconds-of-day.
    pulse_pps(17'd90000);
    chk("badts_state", 32'(state), 1);
    chk("badts_sec", 32'(sec_out), 5);
    chk("badts_subsec", 32'(subsec_out), 0);

    // Capture: strobe, strobe, ack+strobe, ack.
    adv(20);
    cap_strobe = 1'b1; step(); cap_strobe = 1'b0;
    chk("cap1_valid", 32'(cap_valid), 1);
    chk("cap1_sec", 32'(cap_sec), 5);
    chk("cap1_subsec", 32'(cap_subsec), 20);
    chk("cap1_locked", 32'(cap_locked), 0);
    chk("cap1_ovr", 32'(cap_overrun), 0);
    adv(4);
    cap_strobe = 1'b1; step(); cap_strobe = 1'b0;
    chk("cap2_ovr", 32'(cap_overrun), 1);
    chk("cap2_subsec", 32'(cap_subsec), 20);
    adv(4);
    cap_strobe = 1'b1; cap_ack = 1'b1; step(); cap_strobe = 1'b0; cap_ack = 1'b0;
    chk("cap3_valid", 32'(cap_valid), 1);
    chk("cap3_subsec", 32'(cap_subsec), 30);
    chk("cap3_ovr", 32'(cap_overrun), 0);
    cap_ack = 1'b1; step(); cap_ack = 1'b0;
    chk("cap4_valid", 32'(cap_valid), 0);
    chk("cap4_ovr", 32'(cap_overrun), 0);

    // Strobe coincident with pps captures pre-pps time.
    go_to(999);
    cap_strobe = 1'b1; pulse_pps(17'd200); cap_strobe = 1'b0;
    chk("cpps_csec", 32'(cap_sec), 5);
    chk("cpps_csub", 32'(cap_subsec), 999);
    chk("cpps_sec", 32'(sec_out), 200);
    cap_ack = 1'b1; step(); cap_ack = 1'b0;
    go_to(999); pulse_pps(17'd201);
    chk("relock_state", 32'(state), 2);
    adv(3);
    cap_strobe = 1'b1; step(); cap_strobe = 1'b0;
    chk("capl_locked", 32'(cap_locked), 1);
    chk("capl_sec", 32'(cap_sec), 201);
    chk("capl_subsec", 32'(cap_subsec), 3);

    // Async reset in HOLDOVER with a pending snapshot.
    go_to(1009);
    step();
    chk("prerst_state", 32'(state), 3);
    chk("prerst_cvalid", 32'(cap_valid), 1);
    #2 rst = 1'b0;
    #1 chk_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    ss  = 0;
    step();
    chk("post_state", 32'(state), 0);
    chk("post_subsec", 32'(subsec_out), 1);
    chk("post_ppsout", 32'(pps_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
